updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/counter_pkg.sv | 54 +++++
 rtl/register_n.sv | 36 +++
 rtl/updown_counter.sv | 126 ++++++++++++
 tb/tb_updown_counter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared mode constants and next-count step function for the
//               up/down counter. All arithmetic is carried at 33 bits so any
//               counter width up to 32 can use MODULUS = 2**WIDTH without
//               aliasing the top value onto zero.
// Contents    : MODE_WRAP / MODE_SAT   mode constants
//               step_t                 next value plus limit indication
//               next_count()           single inc/dec step with boundary rules
// Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef struct packed {
        logic [32:0] value;
        logic        limit;
    } step_t;

    // One counting step. i_cur and i_max are zero-extended to 33 bits by the
    // caller; i_max is MODULUS-1. inc and dec together is a no-op.
    function automatic step_t next_count(
        input logic [32:0] i_cur,
        input logic [32:0] i_max,
        input logic        i_inc,
        input logic        i_dec,
        input logic        i_sat
    );
        step_t r;
        r.value = i_cur;
        r.limit = 1'b0;
        if (i_inc && !i_dec) begin
            if (i_cur == i_max) begin
                r.limit = 1'b1;
                r.value = i_sat ? i_max : 33'd0;
            end else begin
                r.value = i_cur + 33'd1;
            end
        end else if (i_dec && !i_inc) begin
            if (i_cur == 33'd0) begin
                r.limit = 1'b1;
                r.value = i_sat ? 33'd0 : i_max;
            end else begin
                r.value = i_cur - 33'd1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_n.sv
`default_nettype none
// ============================================================================
// Module      : register_n
// Description : WIDTH-bit storage register with load enable and asynchronous
//               active-low reset to zero.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               i_en   capture i_d on the next rising edge
//               i_d    data in
//               o_q    registered data out
// Revision    : 1.0  initial release
// ============================================================================
module register_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter
// Description : Modulo-N up/down counter with clear, load (clamped to the
//               range), wrap or saturate boundary behaviour, a one-cycle
//               limit pulse, a sticky overflow flag and a load-error pulse.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               i_clr        synchronous clear of count and sticky flag
//               i_load       synchronous load of i_load_val
//               i_load_val   value to load
//               i_inc        count up by one
//               i_dec        count down by one
//               o_count      registered count
//               o_at_zero    count == 0
//               o_at_max     count == MODULUS-1
//               o_limit      pulse: step attempted past a range boundary
//               o_ovf_sticky set by any limit event, held until clear/reset
//               o_load_err   pulse: i_load_val >= MODULUS
// Revision    : 1.0  initial release
// ============================================================================
module updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter logic [32:0] MODULUS  = 33'(1) << WIDTH,
    parameter int          SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_zero,
    output logic             o_at_max,
    output logic             o_limit,
    output logic             o_ovf_sticky,
    output logic             o_load_err
);

    localparam logic [32:0] c_MAX_VAL = MODULUS - 33'd1;
    localparam logic        c_SAT     = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] w_count;
    logic [32:0]      w_count_ext;
    logic [32:0]      w_load_ext;
    logic [32:0]      w_next;
    logic             w_en;
    logic             w_limit_d;
    logic             w_load_err_d;
    step_t            w_step;
    logic             w_unused_hi;

    logic             r_limit;
    logic             r_ovf_sticky;
    logic             r_load_err;

    assign w_count_ext = {{(33-WIDTH){1'b0}}, w_count};
    assign w_load_ext  = {{(33-WIDTH){1'b0}}, i_load_val};
    assign w_step      = next_count(w_count_ext, c_MAX_VAL, i_inc, i_dec, c_SAT);

    // Command priority: clear, then load, then inc/dec, otherwise hold.
    always_comb begin
        w_next       = w_count_ext;
        w_en         = 1'b0;
        w_limit_d    = 1'b0;
        w_load_err_d = 1'b0;
        if (i_clr) begin
            w_next = 33'd0;
            w_en   = 1'b1;
        end else if (i_load) begin
            w_en = 1'b1;
            if (w_load_ext >= MODULUS) begin
                w_next       = c_MAX_VAL;
                w_load_err_d = 1'b1;
            end else begin
                w_next = w_load_ext;
            end
        end else if (i_inc || i_dec) begin
            w_en      = 1'b1;
            w_next    = w_step.value;
            w_limit_d = w_step.limit;
        end
    end

    // Results never exceed MODULUS-1, so bits above WIDTH are always zero.
    assign w_unused_hi = ^w_next[32:WIDTH];

    register_n #(
        .WIDTH (WIDTH)
    ) u_count_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_d   (w_next[WIDTH-1:0]),
        .o_q   (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_limit      <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_limit    <= w_limit_d;
            r_load_err <= w_load_err_d;
            if (i_clr) begin
                r_ovf_sticky <= 1'b0;
            end else if (w_limit_d) begin
                r_ovf_sticky <= 1'b1;
            end
        end
    end

    assign o_count      = w_count;
    assign o_at_zero    = (w_count_ext == 33'd0);
    assign o_at_max     = (w_count_ext == c_MAX_VAL);
    assign o_limit      = r_limit;
    assign o_ovf_sticky = r_ovf_sticky;
    assign o_load_err   = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter
// Description : Self-checking bench for updown_counter. Three instances share
//               the same stimulus: WIDTH=4 MODULUS=10 wrap, WIDTH=4 MODULUS=10
//               saturate, and WIDTH=4 default MODULUS (16) wrap. A modulo
//               arithmetic reference model predicts every output.
// Revision    : 1.0  initial release
// ============================================================================
module tb_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       inc;
    logic       dec;

    logic [3:0] cnt  [3];
    logic       az   [3];
    logic       am   [3];
    logic       lim  [3];
    logic       ovf  [3];
    logic       lerr [3];

    int n_cmp;
    int n_fail;

    // Reference model state per instance.
    int m_cnt [3];
    int m_lim [3];
    int m_ovf [3];
    int m_err [3];
    int c_mod [3] = '{10, 10, 16};
    int c_sat [3] = '{0, 1, 0};

    updown_counter #(.WIDTH(4), .MODULUS(33'd10), .SATURATE(0)) u_wrap10 (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_inc(inc), .i_dec(dec), .o_count(cnt[0]), .o_at_zero(az[0]), .o_at_max(am[0]),
        .o_limit(lim[0]), .o_ovf_sticky(ovf[0]), .o_load_err(lerr[0]));

    updown_counter #(.WIDTH(4), .MODULUS(33'd10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_inc(inc), .i_dec(dec), .o_count(cnt[1]), .o_at_zero(az[1]), .o_at_max(am[1]),
        .o_limit(lim[1]), .o_ovf_sticky(ovf[1]), .o_load_err(lerr[1]));

    updown_counter #(.WIDTH(4), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(load_val),
        .i_inc(inc), .i_dec(dec), .o_count(cnt[2]), .o_at_zero(az[2]), .o_at_max(am[2]),
        .o_limit(lim[2]), .o_ovf_sticky(ovf[2]), .o_load_err(lerr[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic c, input logic l, input int lv,
                          input logic i, input logic d);
        clr      = c;
        load     = l;
        load_val = 4'(lv);
        inc      = i;
        dec      = d;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_lim[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
        end
    endtask

    // One rising edge: update the model from the applied inputs, then settle.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_lim[k] = 0;
            m_err[k] = 0;
            if (clr) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
            end else if (load) begin
                if (int'(load_val) >= c_mod[k]) begin
                    m_cnt[k] = c_mod[k] - 1;
                    m_err[k] = 1;
                end else begin
                    m_cnt[k] = int'(load_val);
                end
            end else if (inc && !dec) begin
                if (m_cnt[k] == c_mod[k] - 1) begin
                    m_lim[k] = 1;
                    m_ovf[k] = 1;
                    if (c_sat[k] == 0) m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = (m_cnt[k] + 1) % c_mod[k];
                end
            end else if (dec && !inc) begin
                if (m_cnt[k] == 0) begin
                    m_lim[k] = 1;
                    m_ovf[k] = 1;
                    if (c_sat[k] == 0) m_cnt[k] = c_mod[k] - 1;
                end else begin
                    m_cnt[k] = (m_cnt[k] + c_mod[k] - 1) % c_mod[k];
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] !== 4'd0 || az[k] !== 1'b1 || lim[k] !== 1'b0 ||
                ovf[k] !== 1'b0 || lerr[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: cnt=%0d az=%b lim=%b ovf=%b lerr=%b, required 0 1 0 0 0",
                         k, cnt[k], az[k], lim[k], ovf[k], lerr[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 9, 0, 0); tick();
        set_in(0, 0, 0, 1, 0); tick();
        set_in(0, 1, 7, 0, 0); tick();
        set_in(0, 0, 0, 1, 0);
        n_cmp++;
        if (cnt[0] !== 4'd7 || ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: cnt=%0d ovf=%b, required 7 1", cnt[0], ovf[0]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] !== 4'd0 || ovf[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: cnt=%0d ovf=%b, required 0 0", k, cnt[k], ovf[k]);
            end
        end
        #1 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (cnt[k] !== 4'd1) begin
                n_fail++;
                $display("FAIL first_after_reset[%0d]: cnt=%0d, required 1", k, cnt[k]);
            end
        end
    endtask

    task automatic test_wrap();
        set_in(0, 1, 9, 0, 0); tick();
        set_in(0, 0, 0, 1, 0); tick();
        n_cmp++;
        if (cnt[0] !== 4'd0 || lim[0] !== 1'b1 || ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_inc: cnt=%0d lim=%b ovf=%b, required 0 1 1", cnt[0], lim[0], ovf[0]);
        end
        set_in(0, 0, 0, 0, 0); tick();
        n_cmp++;
        if (lim[0] !== 1'b0 || ovf[0] !== 1'b1 || cnt[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_idle: cnt=%0d lim=%b ovf=%b, required 0 0 1", cnt[0], lim[0], ovf[0]);
        end
        set_in(0, 0, 0, 0, 1); tick();
        n_cmp++;
        if (cnt[0] !== 4'd9 || lim[0] !== 1'b1 || am[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_dec: cnt=%0d lim=%b am=%b, required 9 1 1", cnt[0], lim[0], am[0]);
        end
    endtask

    task automatic test_saturate();
        set_in(0, 1, 9, 0, 0); tick();
        set_in(0, 0, 0, 1, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++;
            if (cnt[1] !== 4'd9 || lim[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_inc%0d: cnt=%0d lim=%b, required 9 1", n, cnt[1], lim[1]);
            end
        end
        set_in(1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 1); tick();
        n_cmp++;
        if (cnt[1] !== 4'd0 || lim[1] !== 1'b1 || ovf[1] !== 1'b1 || az[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_dec: cnt=%0d lim=%b ovf=%b az=%b, required 0 1 1 1",
                     cnt[1], lim[1], ovf[1], az[1]);
        end
    endtask

    task automatic test_priority();
        set_in(1, 1, 5, 1, 0); tick();
        n_cmp++;
        if (cnt[0] !== 4'd0 || ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_clr: cnt=%0d ovf=%b, required 0 0", cnt[0], ovf[0]);
        end
        set_in(0, 1, 5, 1, 0); tick();
        n_cmp++;
        if (cnt[0] !== 4'd5) begin
            n_fail++;
            $display("FAIL prio_load: cnt=%0d, required 5", cnt[0]);
        end
        set_in(0, 0, 0, 1, 1); tick();
        n_cmp++;
        if (cnt[0] !== 4'd5 || lim[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_incdec: cnt=%0d lim=%b, required 5 0", cnt[0], lim[0]);
        end
    endtask

    task automatic test_load_clamp();
        set_in(0, 1, 12, 0, 0); tick();
        n_cmp++;
        if (cnt[0] !== 4'd9 || lerr[0] !== 1'b1 || am[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp: cnt=%0d lerr=%b am=%b, required 9 1 1", cnt[0], lerr[0], am[0]);
        end
        n_cmp++;
        if (cnt[2] !== 4'd12 || lerr[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp16: cnt=%0d lerr=%b, required 12 0", cnt[2], lerr[2]);
        end
        set_in(0, 0, 0, 0, 0); tick();
        n_cmp++;
        if (lerr[0] !== 1'b0 || cnt[0] !== 4'd9) begin
            n_fail++;
            $display("FAIL clamp_pulse: cnt=%0d lerr=%b, required 9 0", cnt[0], lerr[0]);
        end
    endtask

    task automatic test_full_range();
        int pulses;
        pulses = 0;
        set_in(1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 0);
        for (int n = 0; n < 16; n++) begin
            tick();
            if (lim[2] === 1'b1) pulses++;
        end
        n_cmp++;
        if (cnt[2] !== 4'd0 || az[2] !== 1'b1 || pulses != 1) begin
            n_fail++;
            $display("FAIL full_range: cnt=%0d az=%b pulses=%0d, required 0 1 1",
                     cnt[2], az[2], pulses);
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom % 16) == 0, ($urandom % 8) == 0, int'($urandom % 16),
                   ($urandom % 2) == 1, ($urandom % 2) == 1);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (int'(cnt[k]) != m_cnt[k] || int'(lim[k]) != m_lim[k] ||
                    int'(ovf[k]) != m_ovf[k] || int'(lerr[k]) != m_err[k] ||
                    az[k] !== (m_cnt[k] == 0) || am[k] !== (m_cnt[k] == c_mod[k] - 1)) begin
                    n_fail++;
                    $display("FAIL random[%0d] inst%0d: cnt=%0d lim=%b ovf=%b lerr=%b az=%b am=%b, required %0d %0d %0d %0d %0d %0d",
                             n, k, cnt[k], lim[k], ovf[k], lerr[k], az[k], am[k],
                             m_cnt[k], m_lim[k], m_ovf[k], m_err[k],
                             m_cnt[k] == 0, m_cnt[k] == c_mod[k] - 1);
                end
            end
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_async_reset();
        test_wrap();
        test_saturate();
        test_priority();
        test_load_clamp();
        test_full_range();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
